nand4_exerciser: RTL and testbench
==================================

Name: nand4_exerciser

Overview:
- Self-checking stimulus/response engine for any 4-input NAND gate under test.
- Drives the gate's four inputs through all 16 combinations and samples the gate output after a programmable settle time.
- Compares each sample against the expected NAND value and reports an error count, the first failing vector and a pass/fail verdict.
- Sits on the board or bench beside the gate, on the opposite side of its a/b/c/d -> e interface.

Parameters:
- SETTLE_CYCLES, 2, clock cycles a vector is held before the output is sampled; legal range is 1 to 255.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a sweep; sampled only in IDLE or DONE.
- dut_a, output, 1: gate input a, the MSB of the vector.
- dut_b, output, 1: gate input b.
- dut_c, output, 1: gate input c.
- dut_d, output, 1: gate input d, the LSB of the vector.
- dut_e, input, 1: gate output under test.
- busy, output, 1: high in SETTLE and SAMPLE.
- done, output, 1: high in DONE; level, held until the next start.
- pass, output, 1: equals done and (err_count == 0).
- err_count, output, 5: number of mismatching vectors, 0 to 16.
- first_fail_vec, output, 4: {a,b,c,d} of the first mismatch.
- first_fail_valid, output, 1: first_fail_vec holds a valid value.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state goes to IDLE; vec, settle counter, err_count, first_fail_vec, first_fail_valid and all dut_* outputs go to 0; busy, done and pass go to 0.
- Reset asserted mid-sweep aborts immediately; there is no partial result.
- All outputs are registered or decoded directly from state. No combinational path exists from dut_e to any output.
- {dut_a,dut_b,dut_c,dut_d} = vec in SETTLE and SAMPLE, and 4'b0000 in IDLE and DONE.
- expected = ~(vec[3] & vec[2] & vec[1] & vec[0]).
- IDLE:
  - start = 1 -> SETTLE.
  - On that edge: vec <= 0, cnt <= 0, err_count <= 0, first_fail_valid <= 0.
- SETTLE:
  - cnt increments every cycle; when cnt == SETTLE_CYCLES-1 -> SAMPLE.
  - SETTLE therefore lasts exactly SETTLE_CYCLES cycles per vector.
- SAMPLE (one cycle): at the edge, dut_e is compared with expected.
  - On a mismatch, err_count increments.
  - On a mismatch with first_fail_valid = 0, first_fail_vec <= vec and first_fail_valid <= 1.
  - If vec == 15 -> DONE; otherwise vec <= vec+1, cnt <= 0 -> SETTLE.
- DONE:
  - Results are held stable.
  - start = 1 -> SETTLE with the same initialisation as from IDLE.
- start is ignored while busy; there is no queuing.
- Latency: with start sampled at edge 0, vector k is sampled at edge (k+1)*(SETTLE_CYCLES+1).
- done rises after edge 16*(SETTLE_CYCLES+1); for the default this is edge 48.
- Sweep order is strictly ascending, 0 to 15, with no wrap within a sweep.
- err_count cannot exceed 16, so no saturation logic is needed.
- vec wraps only by re-initialisation on start.

Test Plan:
1. Bench model is a correct NAND, SETTLE_CYCLES=2; pulse start -> busy for 48 cycles, done=1 after edge 48, pass=1, err_count=0, first_fail_valid=0.
2. Bench model is an AND gate -> every vector fails: err_count=16, first_fail_vec=4'b0000, first_fail_valid=1, pass=0.
3. Bench model is stuck-at-1 -> only vector 15 fails: err_count=1, first_fail_vec=4'b1111, pass=0.
4. SETTLE_CYCLES=1 with a correct NAND -> dut inputs step every 2 cycles (0,1,...,15), done after edge 32, pass=1.
5. Pulse start again at cycle 10 while busy -> ignored; done still at edge 48. Then pulse start in DONE -> done drops, err_count clears, a new sweep starts at vec=0.
6. Assert rst_n low at cycle 20 of a sweep -> all outputs 0 immediately, without waiting for a clock edge. Release and pulse start -> a full clean sweep with pass=1.

Source files
------------

// File: rtl/nand4_exerciser.sv
// nand4_exerciser: sweeps a 4-input NAND through all 16 vectors, samples dut_e after SETTLE_CYCLES, reports err_count/first_fail_vec/first_fail_valid/pass/done/busy (clk, async rst_n, start, dut_a..dut_d out, dut_e in)
module nand4_exerciser #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  output logic       dut_c,
  output logic       dut_d,
  input  logic       dut_e,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_vec,
  output logic       first_fail_valid
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);
  logic [1:0] r_state;
  logic [3:0] r_vec;
  logic [7:0] r_cnt;
  logic [4:0] r_err;
  logic [3:0] r_ffv;
  logic       r_ffvalid;
  logic       w_busy;
  logic       w_miss;
  always_comb begin
    w_busy = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    w_miss = dut_e != ~&r_vec;
    {dut_a, dut_b, dut_c, dut_d} = w_busy ? r_vec : 4'b0000;
    busy = w_busy;
    done = r_state == S_DONE;
    pass = (r_state == S_DONE) && (r_err == 5'd0);
    err_count = r_err;
    first_fail_vec = r_ffv;
    first_fail_valid = r_ffvalid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vec     <= 4'd0;
      r_cnt     <= 8'd0;
      r_err     <= 5'd0;
      r_ffv     <= 4'd0;
      r_ffvalid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_SETTLE;
            r_vec     <= 4'd0;
            r_cnt     <= 8'd0;
            r_err     <= 5'd0;
            r_ffvalid <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == LAST_CNT) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (w_miss) begin
            r_err <= r_err + 5'd1;
            if (!r_ffvalid) begin
              r_ffv     <= r_vec;
              r_ffvalid <= 1'b1;
            end
          end
          if (r_vec == 4'hF) begin
            r_state <= S_DONE;
          end else begin
            r_vec   <= r_vec + 4'd1;
            r_cnt   <= 8'd0;
            r_state <= S_SETTLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nand4_exerciser.sv
// tb_nand4_exerciser: directed checks of nand4_exerciser against correct, AND and stuck-at-1 gate models
module tb_nand4_exerciser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  int mode = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic a, b, c, d, e, busy, done, pass, ffval;
  logic [4:0] err;
  logic [3:0] ffv;
  logic a1, b1, c1, d1, e1, busy1, done1, pass1, ffval1;
  logic [4:0] err1;
  logic [3:0] ffv1;
  assign e = (mode == 0) ? ~(a & b & c & d) : (mode == 1) ? (a & b & c & d) : 1'b1;
  assign e1 = ~(a1 & b1 & c1 & d1);
  always #5 clk = ~clk;
  nand4_exerciser #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_a(a), .dut_b(b), .dut_c(c), .dut_d(d), .dut_e(e),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_fail_vec(ffv), .first_fail_valid(ffval)
  );
  nand4_exerciser #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_d(d1), .dut_e(e1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_valid(ffval1)
  );
  task automatic pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({a, b, c, d} !== 4'b0000) begin n_fail++; $display("FAIL reset_vec got %b want 0000", {a, b, c, d}); end
    n_chk++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags busy/done/pass got %b want 000", {busy, done, pass}); end
    n_chk++; if (err !== 5'd0 || ffv !== 4'd0 || ffval !== 1'b0) begin n_fail++; $display("FAIL reset_results err=%0d ffv=%0d ffval=%b want 0/0/0", err, ffv, ffval); end
    n_chk++; if ({busy1, done1, err1} !== 7'd0) begin n_fail++; $display("FAIL reset_dut1 busy=%b done=%b err=%0d want 0", busy1, done1, err1); end
    rst_n = 1'b1;
  endtask
  task automatic test_nand_pass();
    mode = 0;
    pulse();
    for (int t = 0; t < 48; t++) begin
      if (t > 0) @(negedge clk);
      n_chk++;
      if ({a, b, c, d} !== 4'(t / 3) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL nand_sweep edge %0d vec=%b busy=%b done=%b want vec=%0d busy=1 done=0", t, {a, b, c, d}, busy, done, t / 3);
      end
    end
    @(negedge clk);
    n_chk++; if ({done, busy, pass} !== 3'b101) begin n_fail++; $display("FAIL nand_done done/busy/pass got %b want 101", {done, busy, pass}); end
    n_chk++; if (err !== 5'd0 || ffval !== 1'b0) begin n_fail++; $display("FAIL nand_results err=%0d ffval=%b want 0/0", err, ffval); end
    n_chk++; if ({a, b, c, d} !== 4'b0000) begin n_fail++; $display("FAIL nand_done_vec got %b want 0000", {a, b, c, d}); end
  endtask
  task automatic test_and_gate();
    mode = 1;
    pulse();
    repeat (48) @(negedge clk);
    n_chk++; if (err !== 5'd16) begin n_fail++; $display("FAIL and_err got %0d want 16", err); end
    n_chk++; if (ffv !== 4'b0000 || ffval !== 1'b1) begin n_fail++; $display("FAIL and_first got vec=%b valid=%b want 0000/1", ffv, ffval); end
    n_chk++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL and_verdict done/pass got %b want 10", {done, pass}); end
  endtask
  task automatic test_stuck_one();
    mode = 2;
    pulse();
    repeat (48) @(negedge clk);
    n_chk++; if (err !== 5'd1) begin n_fail++; $display("FAIL stuck_err got %0d want 1", err); end
    n_chk++; if (ffv !== 4'b1111 || ffval !== 1'b1) begin n_fail++; $display("FAIL stuck_first got vec=%b valid=%b want 1111/1", ffv, ffval); end
    n_chk++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL stuck_verdict done/pass got %b want 10", {done, pass}); end
  endtask
  task automatic test_settle_one();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int t = 0; t < 32; t++) begin
      if (t > 0) @(negedge clk);
      n_chk++;
      if ({a1, b1, c1, d1} !== 4'(t / 2) || busy1 !== 1'b1 || done1 !== 1'b0) begin
        n_fail++; $display("FAIL settle1_sweep edge %0d vec=%b busy=%b done=%b want vec=%0d busy=1 done=0", t, {a1, b1, c1, d1}, busy1, done1, t / 2);
      end
    end
    @(negedge clk);
    n_chk++; if ({done1, busy1, pass1} !== 3'b101 || err1 !== 5'd0) begin n_fail++; $display("FAIL settle1_done done/busy/pass=%b err=%0d want 101/0", {done1, busy1, pass1}, err1); end
  endtask
  task automatic test_back_to_back();
    mode = 2;
    pulse();
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_chk++; if (busy !== 1'b1 || {a, b, c, d} !== 4'd3) begin n_fail++; $display("FAIL b2b_ignored busy=%b vec=%0d want 1/3", busy, {a, b, c, d}); end
    repeat (37) @(negedge clk);
    n_chk++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_edge47 done=%b busy=%b want 0/1", done, busy); end
    @(negedge clk);
    n_chk++; if (done !== 1'b1 || err !== 5'd1) begin n_fail++; $display("FAIL b2b_edge48 done=%b err=%0d want 1/1", done, err); end
    mode = 0;
    pulse();
    n_chk++; if ({done, busy} !== 2'b01 || err !== 5'd0 || ffval !== 1'b0 || {a, b, c, d} !== 4'd0) begin
      n_fail++; $display("FAIL b2b_restart done=%b busy=%b err=%0d ffval=%b vec=%0d want 0/1/0/0/0", done, busy, err, ffval, {a, b, c, d});
    end
    repeat (48) @(negedge clk);
    n_chk++; if ({done, pass} !== 2'b11 || err !== 5'd0) begin n_fail++; $display("FAIL b2b_second done/pass=%b err=%0d want 11/0", {done, pass}, err); end
  endtask
  task automatic test_reset_mid();
    mode = 1;
    pulse();
    repeat (19) @(negedge clk);
    n_chk++; if (err === 5'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_pre err=%0d busy=%b want nonzero/1", err, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({a, b, c, d} !== 4'b0000 || {busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL mid_async vec=%b flags=%b want 0000/000", {a, b, c, d}, {busy, done, pass}); end
    n_chk++; if (err !== 5'd0 || ffval !== 1'b0 || ffv !== 4'd0) begin n_fail++; $display("FAIL mid_async_results err=%0d ffval=%b ffv=%0d want 0/0/0", err, ffval, ffv); end
    @(negedge clk) rst_n = 1'b1;
    mode = 0;
    pulse();
    repeat (48) @(negedge clk);
    n_chk++; if ({done, pass} !== 2'b11 || err !== 5'd0 || ffval !== 1'b0) begin n_fail++; $display("FAIL mid_resweep done/pass=%b err=%0d ffval=%b want 11/0/0", {done, pass}, err, ffval); end
  endtask
  initial begin
    test_reset();
    test_nand_pass();
    test_and_gate();
    test_stuck_one();
    test_settle_one();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
